// File: rtl/bcd_convert_scheduler.sv
// bcd_convert_scheduler: round-robin time-sharing of one external binary-to-BCD converter with a per-channel result bank.
module bcd_convert_scheduler #(
  parameter int NCH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NCH-1:0]    req_i,
  input  logic [8*NCH-1:0]  bin_in_i,
  output logic [NCH-1:0]    ack_o,
  output logic [7:0]        conv_bin_o,
  input  logic [9:0]        conv_bcd_i,
  output logic [10*NCH-1:0] bcd_out_o,
  output logic [NCH-1:0]    valid_o,
  output logic [NCH-1:0]    upd_o,
  output logic              busy_o
);
  localparam int GW = $clog2(NCH);
  localparam logic IDLE    = 1'b0;
  localparam logic CAPTURE = 1'b1;
  logic           state_q;
  logic [GW-1:0]  last_q, grant_q, g_d;
  logic [7:0]     conv_bin_q;
  logic [NCH-1:0] ack_q, upd_q, valid_q;
  logic [9:0]     bank_q [NCH];
  logic [7:0]     bin [NCH];
  genvar c;
  generate
    for (c = 0; c < NCH; c++) begin : g_ch
      assign bin[c] = bin_in_i[8*c +: 8];
      assign bcd_out_o[10*c +: 10] = bank_q[c];
    end
  endgenerate
  // The second pass overrides the first, so channels above last_q win before wrapping around.
  always_comb begin
    g_d = '0;
    for (int i = NCH - 1; i >= 0; i--) if (req_i[i] && i <= int'(last_q)) g_d = GW'(i);
    for (int i = NCH - 1; i >= 0; i--) if (req_i[i] && i > int'(last_q)) g_d = GW'(i);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      last_q     <= GW'(NCH - 1);
      grant_q    <= '0;
      conv_bin_q <= '0;
      ack_q      <= '0;
      upd_q      <= '0;
      valid_q    <= '0;
      bank_q     <= '{default: '0};
    end else if (state_q == CAPTURE) begin
      bank_q[grant_q]  <= conv_bcd_i;
      valid_q[grant_q] <= 1'b1;
      upd_q            <= NCH'(1) << grant_q;
      last_q           <= grant_q;
      ack_q            <= '0;
      state_q          <= IDLE;
    end else begin
      upd_q <= '0;
      ack_q <= '0;
      if (|req_i) begin
        grant_q    <= g_d;
        conv_bin_q <= bin[g_d];
        ack_q      <= NCH'(1) << g_d;
        state_q    <= CAPTURE;
      end
    end
  end
  assign ack_o      = ack_q;
  assign upd_o      = upd_q;
  assign valid_o    = valid_q;
  assign conv_bin_o = conv_bin_q;
  assign busy_o     = state_q == CAPTURE;
endmodule

// File: tb/tb_bcd_convert_scheduler.sv
// tb_bcd_convert_scheduler: directed and random checks of the converter scheduler against a cycle-level reference model.
module tb_bcd_convert_scheduler;
  localparam int NCH = 4;
  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NCH-1:0]    req = '0;
  logic [8*NCH-1:0]  bin = '0;
  logic [NCH-1:0]    ack, valid, upd;
  logic [7:0]        conv_bin;
  logic [9:0]        conv_bcd;
  logic [10*NCH-1:0] bcd_out;
  logic              busy;
  int tests = 0;
  int fails = 0;
  bit         m_cap;
  int         m_last, m_g;
  logic [7:0] m_conv;
  logic [NCH-1:0] m_ack, m_upd, m_valid;
  logic [9:0] m_bank [NCH];

  always #5 clk = ~clk;

  bcd_convert_scheduler #(.NCH(NCH)) dut (
    .clk(clk), .rst(rst), .req_i(req), .bin_in_i(bin), .ack_o(ack),
    .conv_bin_o(conv_bin), .conv_bcd_i(conv_bcd), .bcd_out_o(bcd_out),
    .valid_o(valid), .upd_o(upd), .busy_o(busy)
  );

  function automatic logic [9:0] to_bcd(input logic [7:0] v);
    int x;
    x = int'(v);
    return {2'(x / 100), 4'((x / 10) % 10), 4'(x % 10)};
  endfunction

  assign conv_bcd = to_bcd(conv_bin);

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_cap = 0; m_last = NCH - 1; m_g = 0; m_conv = '0;
    m_ack = '0; m_upd = '0; m_valid = '0;
    for (int i = 0; i < NCH; i++) m_bank[i] = '0;
  endtask

  task automatic tick();
    logic [10*NCH-1:0] exp_bank;
    if (rst) model_reset();
    else if (m_cap) begin
      m_bank[m_g] = to_bcd(m_conv);
      m_valid[m_g] = 1'b1;
      m_upd = '0; m_upd[m_g] = 1'b1;
      m_ack = '0; m_last = m_g; m_cap = 0;
    end else begin
      m_upd = '0; m_ack = '0;
      if (req != 0) begin
        for (int k = NCH; k >= 1; k--) if (req[(m_last + k) % NCH]) m_g = (m_last + k) % NCH;
        m_conv = bin[8*m_g +: 8];
        m_ack[m_g] = 1'b1;
        m_cap = 1;
      end
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < NCH; i++) exp_bank[10*i +: 10] = m_bank[i];
    chk("ack", 64'(ack), 64'(m_ack));
    chk("upd", 64'(upd), 64'(m_upd));
    chk("valid", 64'(valid), 64'(m_valid));
    chk("busy", 64'(busy), 64'(m_cap));
    chk("conv_bin", 64'(conv_bin), 64'(m_conv));
    chk("bcd_out", 64'(bcd_out), 64'(exp_bank));
  endtask

  function automatic int onehot_idx(input logic [NCH-1:0] v);
    for (int i = 0; i < NCH; i++) if (v[i]) return i;
    return -1;
  endfunction

  initial begin
    logic [7:0] ch2_in [4];
    logic [9:0] ch2_exp [4];
    int order [8];
    int n;
    ch2_in  = '{8'd0, 8'd9, 8'd99, 8'd100};
    ch2_exp = '{10'h000, 10'h009, 10'h099, 10'h100};
    model_reset();
    // reset state
    tick(); tick();
    chk("reset_bcd", 64'(bcd_out), 64'd0);
    rst = 1'b0;
    // channel 0, value 255
    req = 4'b0001; bin[7:0] = 8'd255;
    tick();
    chk("t1_ack0", 64'(ack), 64'b0001);
    req = '0;
    tick();
    chk("t2_bcd0", 64'(bcd_out[9:0]), 64'h255);
    chk("t2_upd0", 64'(upd), 64'b0001);
    chk("t2_others", 64'(bcd_out[39:10]), 64'd0);
    tick();
    // channel 2 boundary values
    for (int j = 0; j < 4; j++) begin
      bin[23:16] = ch2_in[j]; req = 4'b0100;
      tick();
      req = '0;
      tick();
      chk("ch2_bcd", 64'(bcd_out[29:20]), 64'(ch2_exp[j]));
    end
    // all requesting from reset: rotation order
    rst = 1'b1; req = 4'b1111; bin = {8'd40, 8'd30, 8'd20, 8'd10};
    tick();
    rst = 1'b0; n = 0;
    for (int j = 0; j < 16; j++) begin
      tick();
      if (ack != 0 && n < 8) begin order[n] = onehot_idx(ack); n++; end
    end
    chk("rot_count", 64'(n), 64'd8);
    for (int j = 0; j < 8; j++) chk("rot_order", 64'(order[j]), 64'(j % NCH));
    chk("rot_bank", 64'(bcd_out), 64'({10'h040, 10'h030, 10'h020, 10'h010}));
    // priority after channel 1 served
    for (int j = 0; j < 2; j++) begin
      rst = 1'b1; req = '0;
      tick();
      rst = 1'b0; req = 4'b0010;
      tick();
      req = '0;
      tick();
      req = (j == 0) ? 4'b0011 : 4'b0110;
      tick();
      chk("prio_ack", 64'(ack), (j == 0) ? 64'b0001 : 64'b0100);
      req = '0;
      tick();
    end
    // input change during ack is not captured
    bin[31:24] = 8'd42; req = 4'b1000;
    tick();
    bin[31:24] = 8'd7; req = '0;
    tick();
    chk("hold_bcd3", 64'(bcd_out[39:30]), 64'h042);
    // reset during capture
    req = 4'b0001;
    tick();
    rst = 1'b1; req = '0;
    tick();
    chk("abort_upd", 64'(upd), 64'd0);
    chk("abort_bcd", 64'(bcd_out), 64'd0);
    chk("abort_valid", 64'(valid), 64'd0);
    rst = 1'b0; req = 4'b1111;
    tick();
    chk("abort_first", 64'(ack), 64'b0001);
    // random traffic
    for (int j = 0; j < 400; j++) begin
      rst = ($urandom_range(0, 49) == 0);
      req = 4'($urandom);
      bin = $urandom;
      tick();
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
